// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_req_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned GidWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          m_transfer;
    logic                          m_write;
    logic [ADDR_WIDTH-1:0]         m_write_paddr;
    logic [ADDR_WIDTH-1:0]         m_read_paddr;
    logic [DATA_WIDTH-1:0]         m_write_data;

    logic                          bus_psel;
    logic                          bus_penable;
    logic                          bus_pready;
    logic                          bus_pslverr;
    logic [DATA_WIDTH-1:0]         bus_prdata;

    logic                          timeout_flag;
    logic [GidWidth-1:0]           grant_id;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  bus_psel, bus_penable, bus_pready, bus_pslverr, bus_prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_transfer, m_write, m_write_paddr, m_read_paddr, m_write_data,
        output timeout_flag, grant_id
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output bus_psel, bus_penable, bus_pready, bus_pslverr, bus_prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_transfer, m_write, m_write_paddr, m_read_paddr, m_write_data,
        input  timeout_flag, grant_id
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// One request is in flight at a time; completion is observed on the monitored APB bus.
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input logic                Pclk,
    input logic                Preset,
    apb_req_arbiter_if.master  arb_if
);
    localparam int unsigned GidWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT);
    localparam logic [GidWidth-1:0] LastId     = GidWidth'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [GidWidth-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GidWidth-1:0]     grant_q, grant_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    tflag_q, tflag_d;
    logic                    xfer_q, xfer_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]      req_ready;

    logic                    win_found;
    logic [GidWidth-1:0]     win_id;
    logic [GidWidth-1:0]     cand;
    logic                    complete;

    assign complete = arb_if.bus_psel & arb_if.bus_penable & arb_if.bus_pready;

    // Winner: first pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = GidWidth'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && arb_if.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state, request latching, watchdog and response capture.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = '0;
        tflag_d     = tflag_q;
        req_ready   = '0;
        rsp_valid_d = '0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    grant_d = win_id;
                    write_d = arb_if.req_write[win_id];
                    addr_d  = arb_if.req_addr[32'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = arb_if.req_wdata[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // Watchdog only flags; an APB transfer in progress cannot be abandoned.
                cnt_d = (cnt_q != TimeoutVal) ? cnt_q + 1'b1 : cnt_q;
                if (TIMEOUT != 0 && cnt_q == TimeoutVal - 1'b1) begin
                    tflag_d = 1'b1;
                end
                if (complete) begin
                    if (!write_q) begin
                        rdata_d = arb_if.bus_prdata;
                    end
                    err_d   = arb_if.bus_pslverr;
                    cnt_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StResp) begin
            rsp_valid_d[grant_q] = 1'b1;
        end
    end

    assign xfer_d = (state_d == StIssue);

    // State and registered outputs; synchronous active-high reset.
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            tflag_q     <= 1'b0;
            xfer_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            tflag_q     <= tflag_d;
            xfer_q      <= xfer_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign arb_if.req_ready     = req_ready;
    assign arb_if.rsp_valid     = rsp_valid_q;
    assign arb_if.rsp_rdata     = rdata_q;
    assign arb_if.rsp_err       = err_q;
    assign arb_if.m_transfer    = xfer_q;
    assign arb_if.m_write       = write_q;
    assign arb_if.m_write_paddr = addr_q;
    assign arb_if.m_read_paddr  = addr_q;
    assign arb_if.m_write_data  = wdata_q;
    assign arb_if.timeout_flag  = tflag_q;
    assign arb_if.grant_id      = grant_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a cycle-level reference model and APB bus emulator.
module tb_apb_req_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic Pclk = 1'b0;
    logic Preset = 1'b1;
    always #5 Pclk = ~Pclk;

    apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .Pclk   (Pclk),
        .Preset (Preset),
        .arb_if (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always begin
        @(posedge Pclk);
        cyc++;
    end

    // Slave-side controls read by the bus emulator.
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    logic        slv_hang  = 1'b0;

    // APB master+slave emulation: SETUP the cycle after transfer, then ACCESS until pready.
    initial begin
        int w;
        bit done;
        ifc.bus_psel = 0; ifc.bus_penable = 0; ifc.bus_pready = 0;
        ifc.bus_pslverr = 0; ifc.bus_prdata = '0;
        forever begin
            @(negedge Pclk);
            if (ifc.m_transfer === 1'b1 && Preset === 1'b0) begin
                @(posedge Pclk); #1;
                ifc.bus_psel = 1; ifc.bus_penable = 0;
                @(posedge Pclk); #1;
                ifc.bus_penable = 1;
                w = 0;
                done = 0;
                for (int n = 0; n < 5000 && !done; n++) begin
                    if (!slv_hang && w >= slv_wait) begin
                        ifc.bus_pready = 1; ifc.bus_prdata = slv_rdata; ifc.bus_pslverr = slv_err;
                    end else begin
                        ifc.bus_pready = 0;
                    end
                    @(posedge Pclk);
                    if (Preset || ifc.bus_pready) done = 1;
                    else w++;
                    #1;
                end
                ifc.bus_psel = 0; ifc.bus_penable = 0; ifc.bus_pready = 0; ifc.bus_pslverr = 0;
            end
        end
    end

    // Reference model: one transaction in flight, tracked by its age since acceptance.
    bit          armed = 0;
    bit          m_busy, m_resp, m_wr, m_err, m_tflag;
    int          m_age, m_rr, m_gid, m_wcnt;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic int rr_winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N] === 1'b1) return (rr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        int w;
        forever begin
            @(posedge Pclk);
            if (Preset) begin
                armed = 1;
                m_busy = 0; m_resp = 0; m_wr = 0; m_err = 0; m_tflag = 0;
                m_age = 0; m_rr = 0; m_gid = 0; m_wcnt = 0;
                m_addr = 0; m_wdata = 0; m_rdata = 0;
            end else if (armed) begin
                if (!m_busy) begin
                    w = rr_winner(ifc.req_valid, m_rr);
                    if (w >= 0) begin
                        m_busy = 1; m_age = 1; m_wcnt = 0; m_gid = w;
                        m_wr    = ifc.req_write[w];
                        m_addr  = ifc.req_addr[w*32 +: 32];
                        m_wdata = ifc.req_wdata[w*32 +: 32];
                    end
                end else if (m_resp) begin
                    m_busy = 0; m_resp = 0;
                    m_rr = (m_gid + 1) % N;
                end else if (m_age == 1) begin
                    m_age = 2;
                end else begin
                    m_wcnt++;
                    if (m_wcnt >= TO) m_tflag = 1;
                    if (ifc.bus_psel && ifc.bus_penable && ifc.bus_pready) begin
                        m_resp = 1;
                        if (!m_wr) m_rdata = ifc.bus_prdata;
                        m_err = ifc.bus_pslverr;
                    end
                end
            end
        end
    end

    // Event log plus per-cycle comparison against the model.
    int xfer_cnt = 0, xfer_cyc = -1, rsp_cnt = 0;
    int acc_ids[$];
    int acc_cycs[$];

    initial begin
        logic [N-1:0] exp_ready;
        int w;
        forever begin
            @(negedge Pclk);
            if (armed) begin
                exp_ready = '0;
                if (!m_busy) begin
                    w = rr_winner(ifc.req_valid, m_rr);
                    if (w >= 0) exp_ready[w] = 1'b1;
                end
                chk("req_ready", ifc.req_ready, exp_ready);
                chk("rsp_valid", ifc.rsp_valid, m_resp ? (64'd1 << m_gid) : 64'd0);
                chk("m_transfer", ifc.m_transfer, (m_busy && m_age == 1) ? 1 : 0);
                chk("rsp_rdata", ifc.rsp_rdata, m_rdata);
                chk("rsp_err", ifc.rsp_err, m_err);
                chk("m_write", ifc.m_write, m_wr);
                chk("m_write_paddr", ifc.m_write_paddr, m_addr);
                chk("m_read_paddr", ifc.m_read_paddr, m_addr);
                chk("m_write_data", ifc.m_write_data, m_wdata);
                chk("timeout_flag", ifc.timeout_flag, m_tflag);
                chk("grant_id", ifc.grant_id, m_gid);
            end
            if (ifc.m_transfer === 1'b1) begin xfer_cnt++; xfer_cyc = cyc; end
            if (ifc.rsp_valid !== '0) rsp_cnt++;
            for (int i = 0; i < N; i++) begin
                if (ifc.req_ready[i] === 1'b1) begin
                    acc_ids.push_back(i);
                    acc_cycs.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge Pclk); #1;
    endtask

    task automatic do_reset();
        Preset = 1; step(); step(); Preset = 0;
    endtask

    task automatic accept(input int id, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, output int t);
        step();
        ifc.req_write[id] = wr;
        ifc.req_addr[id*32 +: 32] = addr;
        ifc.req_wdata[id*32 +: 32] = data;
        ifc.req_valid[id] = 1'b1;
        t = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge Pclk);
            if (ifc.req_ready[id] === 1'b1) begin t = cyc; break; end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL accept_%0d: req_ready got 0 want 1 within 100 cycles", id);
        end
        step();
        ifc.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int id, input int t, input int lat);
        for (int n = 0; n < 200; n++) begin
            @(negedge Pclk);
            if (ifc.rsp_valid !== '0) break;
        end
        chk({name, "_rsp_valid"}, ifc.rsp_valid, 64'd1 << id);
        chk({name, "_latency"}, cyc - t, lat);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge Pclk);
    endtask

    initial begin
        int t, x0, r0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] drop;
        bit re;
        ifc.req_valid = '0; ifc.req_write = '0; ifc.req_addr = '0; ifc.req_wdata = '0;

        // Reset state
        step(); step(); Preset = 0;
        @(negedge Pclk);
        chk("rst_grant_id", ifc.grant_id, 0);
        chk("rst_m_transfer", ifc.m_transfer, 0);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_timeout", ifc.timeout_flag, 0);
        chk("rst_paddr", ifc.m_write_paddr, 0);

        // Requester 2 write, zero-wait slave
        x0 = xfer_cnt;
        accept(2, 1'b1, 32'h10, 32'hA5A5_0001, t);
        wait_rsp("t1", 2, t, 4);
        chk("t1_rsp_err", ifc.rsp_err, 0);
        chk("t1_xfer_when", xfer_cyc - t, 1);
        chk("t1_xfer_count", xfer_cnt - x0, 1);

        // All four read at once from rr_ptr 0; requester 0 re-asserts after its accept
        do_reset();
        acc_ids.delete(); acc_cycs.delete();
        for (int i = 0; i < N; i++) begin
            ifc.req_write[i] = 1'b0;
            ifc.req_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
        end
        ifc.req_valid = 4'hF;
        re = 0;
        for (int n = 0; n < 200 && acc_ids.size() < 5; n++) begin
            @(negedge Pclk);
            drop = ifc.req_ready;
            step();
            if (drop == 4'b0001 && !re) begin re = 1; drop = '0; end
            ifc.req_valid = ifc.req_valid & ~drop;
        end
        ifc.req_valid = '0;
        chk("t2_accepts", acc_ids.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < acc_ids.size()) chk("t2_order", acc_ids[i], exp_order[i]);
            if (i > 0 && i < acc_cycs.size()) chk("t2_spacing", acc_cycs[i] - acc_cycs[i-1], 5);
        end
        repeat (6) step();

        // Read from requester 1 with three slave wait cycles
        slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
        accept(1, 1'b0, 32'h2000, 32'h0, t);
        wait_rsp("t3", 1, t, 7);
        chk("t3_rdata", ifc.rsp_rdata, 32'hDEAD_BEEF);
        slv_wait = 0;

        // Pslverr on a write, then a clean read
        slv_err = 1; slv_rdata = 32'hFFFF_0000;
        accept(2, 1'b1, 32'h3000, 32'h55, t);
        wait_rsp("t4a", 2, t, 4);
        chk("t4a_err", ifc.rsp_err, 1);
        chk("t4a_rdata_held", ifc.rsp_rdata, 32'hDEAD_BEEF);
        slv_err = 0; slv_rdata = 32'h1234_5678;
        accept(3, 1'b0, 32'h3004, 32'h0, t);
        wait_rsp("t4b", 3, t, 4);
        chk("t4b_err", ifc.rsp_err, 0);
        chk("t4b_rdata", ifc.rsp_rdata, 32'h1234_5678);

        // Watchdog: pready held low past TIMEOUT
        slv_hang = 1;
        accept(0, 1'b0, 32'h40, 32'h0, t);
        wait_cyc(t + 9);
        chk("t5_flag_before", ifc.timeout_flag, 0);
        @(negedge Pclk);
        chk("t5_flag_set", ifc.timeout_flag, 1);
        wait_cyc(t + 15);
        chk("t5_flag_held", ifc.timeout_flag, 1);
        step();
        slv_hang = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge Pclk);
            if (ifc.rsp_valid !== '0) break;
        end
        chk("t5_rsp_valid", ifc.rsp_valid, 4'b0001);
        step(); step();
        chk("t5_flag_after", ifc.timeout_flag, 1);

        // Reset during WAIT: no response, then arbitration restarts from 0
        slv_hang = 1;
        accept(3, 1'b0, 32'h50, 32'h0, t);
        wait_cyc(t + 4);
        r0 = rsp_cnt;
        do_reset();
        slv_hang = 0;
        repeat (10) step();
        chk("t6_no_rsp", rsp_cnt - r0, 0);
        chk("t6_grant_id", ifc.grant_id, 0);
        chk("t6_flag_cleared", ifc.timeout_flag, 0);
        acc_ids.delete(); acc_cycs.delete();
        ifc.req_valid = 4'b1001;
        for (int n = 0; n < 20 && acc_ids.size() < 1; n++) @(negedge Pclk);
        step();
        ifc.req_valid = '0;
        chk("t6_first_grant", (acc_ids.size() > 0) ? acc_ids[0] : -1, 0);
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares one `apb_master` between `NUM_REQ` requesters. It accepts one request at a time, drives the master's transfer-side inputs, and watches the APB bus for completion. It then returns read data and the error status to the winning requester. It sits directly in front of `apb_master` and replaces the single "previous system" that drives it today.

## Interface
- `NUM_REQ`, default 4: number of requesters (1..16).
- `ADDR_WIDTH`, default 32: APB address width; matches `` `ADDR_WIDTH``.
- `DATA_WIDTH`, default 32: APB data width; matches `` `DATA_WIDTH``.
- `TIMEOUT`, default 64: WAIT-state watchdog limit in cycles; 0 disables it.

Ports:
- `Pclk` in 1: clock; everything is on the rising edge.
- `Preset` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data, sliced the same way.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `rsp_valid` out NUM_REQ: one-hot completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, shared by all requesters.
- `rsp_err` out 1: Pslverr captured at completion.
- `m_transfer` out 1: connects to master `transfer`.
- `m_write` out 1: connects to master `WRITE_READ`.
- `m_write_paddr` out ADDR_WIDTH: connects to master `APB_write_paddr`.
- `m_read_paddr` out ADDR_WIDTH: connects to master `APB_read_paddr`.
- `m_write_data` out DATA_WIDTH: connects to master `APB_write_data`.
- `bus_psel`, `bus_penable`, `bus_pready`, `bus_pslverr` in 1 each: monitored APB signals.
- `bus_prdata` in DATA_WIDTH: monitored APB read data.
- `timeout_flag` out 1: sticky watchdog error.
- `grant_id` out $clog2(NUM_REQ) (minimum 1): index of the requester currently being served.

## Operation
State machine states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, the winner is the first set bit searched upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` is driven combinationally high in this cycle. The winner's write, address and data are latched at the clock edge, `grant_id` takes the winner, and the FSM moves to ISSUE.
  - If no bit is set, the FSM stays in IDLE.
- **ISSUE:** `m_transfer` is 1 for exactly this one cycle; the FSM then moves to WAIT.
- **WAIT:**
  - Completion is `bus_psel & bus_penable & bus_pready`.
  - On completion: `rsp_rdata` takes `bus_prdata` (reads only; it holds its old value on writes), `rsp_err` takes `bus_pslverr`, and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid[grant_id]` is 1 for this cycle.
  - `rr_ptr` becomes `(grant_id+1) mod NUM_REQ`.
  - The FSM then moves to IDLE.
- **Master-side outputs:**
  - `m_write`, `m_write_paddr`, `m_read_paddr` and `m_write_data` come from the latched request.
  - They stay stable from ISSUE through RESP, because the master samples `WRITE_READ` during ACCESS.
  - `m_write_paddr` and `m_read_paddr` both carry the latched address.
- **Watchdog:**
  - A counter increments on every WAIT cycle and clears when the FSM leaves WAIT.
  - When it reaches `TIMEOUT`, `timeout_flag` is set and held until reset.
  - The FSM stays in WAIT; an APB transfer cannot be aborted.
  - The counter saturates at `TIMEOUT`.
- **Outputs during RESP:** `req_ready` is 0 outside IDLE. `rsp_rdata` and `rsp_err` hold their values until the next completion.

## Timing
- Reset values, applied on the edge where `Preset` is sampled high:
  - FSM = IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - `m_transfer`, `m_write`, `rsp_valid`, `rsp_err` and `timeout_flag` are 0.
  - All address and data outputs are 0.
- Reset asserted mid-operation abandons the transfer with no `rsp_valid`. Resetting the master is the system's responsibility.
- All outputs are registered except `req_ready`.
- Latency from the accept cycle T, with a zero-wait-state slave:
  - T+1: ISSUE.
  - T+2: master SETUP, `bus_psel`=1.
  - T+3: ACCESS with `bus_pready`=1.
  - T+4: `rsp_valid`.
  - Each extra slave wait cycle adds 1.
- Throughput: a new accept can happen no earlier than T+5. Since `m_transfer` is low at the completing ACCESS edge, the master always returns to IDLE and never chains transfers back-to-back.
- Simultaneous requests are served strictly round-robin; no requester waits behind more than NUM_REQ-1 others.
- A `req_valid` that is deasserted before its `req_ready` is simply dropped. A requester asserting again while its own response is pending waits until IDLE.
- Pslverr completes the transaction normally, with `rsp_err`=1.

## Test plan
- Reset → all outputs 0, `grant_id`=0. Requester 2 writes 0xA5A5_0001 to address 0x10 → `m_transfer` high exactly one cycle at T+1, `rsp_valid`=4'b0100 at T+4, `rsp_err`=0.
- All four requesters assert reads at once with `rr_ptr`=0 → grants in order 0,1,2,3. Issuing 0 again afterwards → grant goes to 0 only after 3.
- Read from requester 1 with slave wait of 3 cycles and `bus_prdata`=0xDEAD_BEEF → `rsp_valid[1]` at T+7, `rsp_rdata`=0xDEADBEEF.
- Slave returns Pslverr=1 on a write → `rsp_err`=1 and `rsp_valid` pulses. The next clean transfer → `rsp_err`=0.
- `TIMEOUT`=8 and `bus_pready` held low → `timeout_flag` rises after 8 WAIT cycles and stays set. Releasing Pready → the transfer completes and the flag stays 1.
- Assert `Preset` during WAIT → FSM returns to IDLE and no `rsp_valid` is produced. The next request is granted with `rr_ptr`=0.
